periph_bus_ctrl: RTL and testbench

- Parametrised peripheral-bus controller between the CPU wishbone master and NSLV I/O slaves (floppy, latches, podules, IOC class).
- Replaces the flat combinational read-data priority mux with a registered transaction engine that adds:
  - per-access speed-class wait states;
  - slave error forwarding;
  - a bus timeout;
  - all-ones read data for unmapped accesses.
- Address decode stays external: the controller receives one select bit per slave.

---
 rtl/periph_bus_ctrl.sv | 121 ++++++++++++
 tb/tb_periph_bus_ctrl.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/periph_bus_ctrl.sv
// periph_bus_ctrl: registered transaction engine between the CPU master and NSLV I/O slaves,
// adding speed-class wait states, error forwarding, a bus timeout and unmapped-access answers.
module periph_bus_ctrl #(
  parameter int NSLV      = 4,
  parameter int DW        = 32,
  parameter int WS_STEP   = 4,
  parameter int TMO       = 255,
  parameter bit UNMAP_ERR = 1'b0
) (
  input  logic               clkcpu,
  input  logic               rst_n_i,
  input  logic               m_cyc,
  input  logic               m_stb,
  input  logic               m_we,
  output logic [DW-1:0]      m_dat_i,
  output logic               m_ack,
  output logic               m_err,
  input  logic [NSLV-1:0]    slv_sel,
  input  logic [1:0]         speed_i,
  output logic [NSLV-1:0]    s_cyc,
  output logic [NSLV-1:0]    s_stb,
  output logic               s_we,
  input  logic [NSLV*DW-1:0] s_dat_i,
  input  logic [NSLV-1:0]    s_ack,
  input  logic [NSLV-1:0]    s_err,
  output logic               busy_o,
  output logic               tmo_o
);
  localparam int IW = (NSLV > 1) ? $clog2(NSLV) : 1;

  typedef enum logic [1:0] {IDLE, WAIT, RESP, DONE} state_t;

  state_t          r_state, w_next;
  logic [IW-1:0]   r_idx, w_idx;
  logic            r_we, r_seen, r_err, r_tmo;
  logic [7:0]      r_ws, r_cnt;
  logic [DW-1:0]   r_dat, w_sdat;
  logic [NSLV-1:0] w_oh;
  logic            w_start, w_unmap, w_sack, w_serr, w_done, w_tmo;

  // Lowest set select wins; slave inputs are only ever looked at on the latched channel.
  always_comb begin
    w_idx = '0;
    w_sdat = '0;
    for (int k = NSLV - 1; k >= 0; k--)
      if (slv_sel[k]) w_idx = IW'(k);
    for (int k = 0; k < NSLV; k++)
      if (r_idx == IW'(k)) w_sdat = s_dat_i[k*DW +: DW];
  end

  assign w_oh    = NSLV'(1) << r_idx;
  assign w_start = m_cyc & m_stb;
  assign w_unmap = ~|slv_sel;
  assign w_sack  = |(s_ack & w_oh);
  assign w_serr  = |(s_err & w_oh);
  assign w_done  = (r_ws == 8'd0) & (r_seen | w_sack);
  assign w_tmo   = (r_cnt == 8'(TMO - 1)) & ~r_seen & ~w_sack;

  always_ff @(posedge clkcpu or negedge rst_n_i)
    if (!rst_n_i) r_state <= IDLE;
    else          r_state <= w_next;

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    w_next = !w_start ? IDLE : w_unmap ? RESP : WAIT;
      WAIT:    w_next = !m_cyc ? IDLE : (w_serr | w_done | w_tmo) ? RESP : WAIT;
      default: w_next = m_stb ? DONE : IDLE;
    endcase
  end

  always_ff @(posedge clkcpu or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_idx  <= '0;
      r_we   <= 1'b0;
      r_ws   <= 8'd0;
      r_cnt  <= 8'd0;
      r_seen <= 1'b0;
      r_err  <= 1'b0;
      r_tmo  <= 1'b0;
      r_dat  <= '1;
    end else if (r_state == IDLE && w_start) begin
      r_idx  <= w_idx;
      r_we   <= m_we;
      r_ws   <= 8'(32'(speed_i) * WS_STEP);
      r_cnt  <= 8'd0;
      r_seen <= 1'b0;
      r_err  <= w_unmap & UNMAP_ERR;
      r_tmo  <= 1'b0;
      if (w_unmap) r_dat <= '1;
    end else if (r_state == WAIT && m_cyc) begin
      r_cnt <= r_cnt + 8'd1;
      if (w_serr) begin
        r_dat <= w_sdat;
        r_err <= 1'b1;
      end else if (w_tmo) begin
        r_dat <= '1;
        r_err <= 1'b1;
        r_tmo <= 1'b1;
      end else begin
        // An early ack is held while the remaining wait states run out.
        if (w_sack && !r_seen) begin
          r_dat  <= w_sdat;
          r_seen <= 1'b1;
        end
        if (r_ws != 8'd0) r_ws <= r_ws - 8'd1;
      end
    end
  end

  always_comb begin
    busy_o  = r_state != IDLE;
    m_ack   = (r_state == RESP) & ~r_err;
    m_err   = (r_state == RESP) & r_err;
    tmo_o   = (r_state == RESP) & r_tmo;
    s_cyc   = (r_state == WAIT) ? w_oh : '0;
    s_stb   = (r_state == WAIT && !r_seen) ? w_oh : '0;
    s_we    = r_we;
    m_dat_i = r_dat;
  end
endmodule

// File: tb/tb_periph_bus_ctrl.sv
// tb_periph_bus_ctrl: randomized transactions against a timeline model of the controller,
// with two instances differing only in how unmapped accesses are answered.
module tb_periph_bus_ctrl;
  localparam int WS  = 4;
  localparam int TMO = 255;
  localparam logic [31:0] ONES = 32'hFFFF_FFFF;

  logic         clkcpu = 1'b0, rst_n_i = 1'b0;
  logic         m_cyc = 1'b0, m_stb = 1'b0, m_we = 1'b0;
  logic [3:0]   slv_sel = '0, s_ack = '0, s_err = '0;
  logic [1:0]   speed_i = '0;
  logic [127:0] s_dat_i = '0;
  logic [31:0]  m_dat_i, mb_dat;
  logic         m_ack, m_err, s_we, busy_o, tmo_o;
  logic         mb_ack, mb_err, mb_swe, mb_busy, mb_tmo;
  logic [3:0]   s_cyc, s_stb, mb_scyc, mb_sstb;

  periph_bus_ctrl #(.NSLV(4), .DW(32), .WS_STEP(WS), .TMO(TMO), .UNMAP_ERR(1'b0)) u_dut (
    .clkcpu(clkcpu), .rst_n_i(rst_n_i), .m_cyc(m_cyc), .m_stb(m_stb), .m_we(m_we),
    .m_dat_i(m_dat_i), .m_ack(m_ack), .m_err(m_err), .slv_sel(slv_sel), .speed_i(speed_i),
    .s_cyc(s_cyc), .s_stb(s_stb), .s_we(s_we), .s_dat_i(s_dat_i), .s_ack(s_ack),
    .s_err(s_err), .busy_o(busy_o), .tmo_o(tmo_o));

  periph_bus_ctrl #(.NSLV(4), .DW(32), .WS_STEP(WS), .TMO(TMO), .UNMAP_ERR(1'b1)) u_dut_b (
    .clkcpu(clkcpu), .rst_n_i(rst_n_i), .m_cyc(m_cyc), .m_stb(m_stb), .m_we(m_we),
    .m_dat_i(mb_dat), .m_ack(mb_ack), .m_err(mb_err), .slv_sel(slv_sel), .speed_i(speed_i),
    .s_cyc(mb_scyc), .s_stb(mb_sstb), .s_we(mb_swe), .s_dat_i(s_dat_i), .s_ack(s_ack),
    .s_err(s_err), .busy_o(mb_busy), .tmo_o(mb_tmo));

  always #5 clkcpu = ~clkcpu;

  int tests = 0, fails = 0, cyc = 0;
  int rsp_n = 0, rsp_cyc = 0, tmo_n = 0, tmo_cyc = 0, stb1_cnt = 0;
  logic [31:0] rsp_dat = '0;
  logic        rsp_err = 1'b0;
  logic [3:0]  stb_or = '0;

  logic        e_ack, e_err, e_ackb, e_errb, e_tmo, e_busy, e_dat_v, e_we_v, e_we;
  logic [3:0]  e_scyc, e_sstb;
  logic [31:0] e_dat;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h want %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  always @(posedge clkcpu) cyc <= cyc + 1;

  always @(negedge clkcpu) begin
    chk("m_ack", 32'(m_ack), 32'(e_ack));
    chk("m_err", 32'(m_err), 32'(e_err));
    chk("b_m_ack", 32'(mb_ack), 32'(e_ackb));
    chk("b_m_err", 32'(mb_err), 32'(e_errb));
    chk("tmo_o", 32'(tmo_o), 32'(e_tmo));
    chk("b_tmo_o", 32'(mb_tmo), 32'(e_tmo));
    chk("busy_o", 32'(busy_o), 32'(e_busy));
    chk("b_busy_o", 32'(mb_busy), 32'(e_busy));
    chk("s_cyc", 32'(s_cyc), 32'(e_scyc));
    chk("s_stb", 32'(s_stb), 32'(e_sstb));
    chk("b_s_stb", 32'(mb_sstb), 32'(e_sstb));
    if (e_dat_v) begin
      chk("m_dat_i", m_dat_i, e_dat);
      chk("b_m_dat_i", mb_dat, e_dat);
    end
    if (e_we_v) chk("s_we", 32'(s_we), 32'(e_we));
    if (m_ack | m_err) begin
      rsp_n++;
      rsp_cyc = cyc;
      rsp_dat = m_dat_i;
      rsp_err = m_err;
    end
    if (tmo_o) begin
      tmo_n++;
      tmo_cyc = cyc;
    end
    stb1_cnt += 32'(s_stb[1]);
    stb_or |= s_stb;
  end

  task automatic tick();
    @(posedge clkcpu);
    #1;
  endtask

  task automatic idle_exp();
    e_ack = 0; e_err = 0; e_ackb = 0; e_errb = 0; e_tmo = 0; e_busy = 0;
    e_scyc = '0; e_sstb = '0; e_we_v = 0;
  endtask

  // Slave side: the chosen channel follows the script, all others carry random noise.
  task automatic drv_slv(input int idx, input logic a, input logic e, input logic [31:0] d);
    for (int k = 0; k < 4; k++) begin
      s_ack[k] = (k == idx) ? a : 1'($urandom_range(0, 1));
      s_err[k] = (k == idx) ? e : ($urandom_range(0, 3) == 0);
      s_dat_i[k*32 +: 32] = (k == idx) ? d : $urandom;
    end
  endtask

  // One master transaction. d/e: WAIT cycle (0 = first strobe cycle) of slave ack/error;
  // a: WAIT cycle in which the master drops m_cyc; hold: DONE cycles with m_stb still high.
  task automatic txn(input logic [3:0] sel, input logic [1:0] sp, input logic we,
                     input bit has_ack, input int d, input bit has_err, input int e,
                     input bit ab, input int a, input bit dup, input int hold,
                     input logic [31:0] dat, output int n_cyc);
    int idx, ws0, jr;
    bit unm, is_err, is_tmo, aborted;
    logic [3:0] oh;
    logic [31:0] rdat, dv;
    unm = (sel == 4'd0);
    idx = 0;
    while (!unm && !sel[idx]) idx++;
    oh = 4'(1 << idx);
    ws0 = int'(sp) * WS;
    aborted = 0;
    if (unm) begin
      jr = -1; is_err = 0; is_tmo = 0; rdat = ONES;
    end else if (has_err) begin
      jr = e; is_err = 1; is_tmo = 0; rdat = dat;
    end else if (has_ack && d <= TMO - 1) begin
      jr = (d > ws0) ? d : ws0; is_err = 0; is_tmo = 0; rdat = dat;
    end else begin
      jr = TMO - 1; is_err = 1; is_tmo = 1; rdat = ONES;
    end
    m_cyc = 1; m_stb = 1; m_we = we; slv_sel = sel; speed_i = sp;
    drv_slv(-1, 0, 0, 0);
    idle_exp();
    n_cyc = cyc;
    tick();
    if (!unm) begin
      for (int j = 0; ; j++) begin
        m_cyc = !(ab && j == a);
        slv_sel = 4'($urandom);
        speed_i = 2'($urandom);
        dv = (j == d || j == e) ? dat : (dup && j == d + 1) ? ~dat : $urandom;
        drv_slv(idx, has_ack && (j == d || (dup && j == d + 1)), has_err && j == e, dv);
        idle_exp();
        e_busy = 1; e_scyc = oh; e_sstb = (!has_ack || j <= d) ? oh : 4'd0;
        e_we_v = 1; e_we = we; e_dat_v = 0;
        tick();
        if (ab && j == a) begin
          aborted = 1;
          break;
        end
        if (j == jr) break;
      end
    end
    if (aborted) begin
      m_cyc = 0; m_stb = 0;
      drv_slv(idx, 1, 0, $urandom);
      idle_exp();
      tick();
    end else begin
      m_cyc = 1; m_stb = (hold > 0);
      drv_slv(-1, 0, 0, 0);
      idle_exp();
      e_busy = 1; e_ack = !is_err; e_err = is_err;
      e_ackb = unm ? 1'b0 : !is_err; e_errb = unm ? 1'b1 : is_err;
      e_tmo = is_tmo; e_dat_v = 1; e_dat = rdat;
      tick();
      for (int h = 1; h <= hold; h++) begin
        m_stb = (h < hold);
        drv_slv(-1, 0, 0, 0);
        idle_exp();
        e_busy = 1;
        tick();
      end
      m_cyc = 0; m_stb = 0;
      idle_exp();
      tick();
    end
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int n, r0, t0, s0, d, e, a, hold;
    bit ha, he, ab, dup;
    idle_exp();
    e_dat_v = 1; e_dat = ONES; e_we = 0;
    repeat (3) tick();
    rst_n_i = 1;
    tick();

    txn(4'b0010, 2'd0, 0, 1, 0, 0, 0, 0, 0, 0, 1, 32'h0000_00A5, n);
    s0 = stb1_cnt;
    r0 = rsp_n;
    chk("speed0_latency", rsp_cyc - n, 2);
    chk("speed0_data", rsp_dat, 32'h0000_00A5);
    stb1_cnt = 0;
    txn(4'b0010, 2'd0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 32'h0000_00A5, n);
    chk("speed0_stb1_cycles", stb1_cnt, 1);

    t0 = tmo_n;
    txn(4'b0001, 2'd2, 0, 1, 0, 0, 0, 0, 0, 1, 0, 32'h1234_5678, n);
    chk("ws_latency", rsp_cyc - n, 10);
    chk("ws_data", rsp_dat, 32'h1234_5678);
    chk("ws_no_tmo", tmo_n - t0, 0);

    txn(4'b0000, 2'd1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h0, n);
    chk("unmap_latency", rsp_cyc - n, 1);
    chk("unmap_data", rsp_dat, ONES);
    chk("unmap_is_ack", 32'(rsp_err), 0);

    txn(4'b0100, 2'd1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 32'h0, n);
    chk("timeout_latency", rsp_cyc - n, 256);
    chk("timeout_tmo_cycle", tmo_cyc - n, 256);
    chk("timeout_is_err", 32'(rsp_err), 1);
    chk("timeout_data", rsp_dat, ONES);

    stb_or = '0;
    txn(4'b1100, 2'd0, 0, 1, 1, 0, 0, 0, 0, 0, 0, 32'hCAFE_0002, n);
    chk("prio_stb_seen", 32'(stb_or), 32'h4);

    r0 = rsp_n;
    txn(4'b0001, 2'd3, 0, 1, 5, 0, 0, 1, 2, 0, 0, 32'h0, n);
    chk("abort_no_response", rsp_n - r0, 0);

    txn(4'b1000, 2'd0, 0, 1, 1, 1, 1, 0, 0, 0, 1, 32'hDEAD_0008, n);
    chk("ack_err_is_err", 32'(rsp_err), 1);
    chk("ack_err_data", rsp_dat, 32'hDEAD_0008);

    // Reset in the middle of a WAIT with a slave that would ack right after.
    m_cyc = 1; m_stb = 1; m_we = 1; slv_sel = 4'b0001; speed_i = 2'd3;
    drv_slv(-1, 0, 0, 0);
    idle_exp();
    tick();
    drv_slv(0, 0, 0, $urandom);
    idle_exp();
    e_busy = 1; e_scyc = 4'b0001; e_sstb = 4'b0001; e_we_v = 1; e_we = 1; e_dat_v = 0;
    tick();
    rst_n_i = 0; m_cyc = 0; m_stb = 0;
    idle_exp();
    e_dat_v = 1; e_dat = ONES;
    #1;
    chk("reset_busy_async", 32'(busy_o), 0);
    chk("reset_stb_async", 32'(s_stb), 0);
    r0 = rsp_n;
    tick();
    tick();
    rst_n_i = 1;
    drv_slv(0, 1, 0, 32'h1111_1111);
    repeat (3) tick();
    chk("reset_no_ack_after", rsp_n - r0, 0);

    for (int i = 0; i < 120; i++) begin
      d = $urandom_range(0, 15);
      ha = ($urandom_range(0, 9) != 0);
      he = ($urandom_range(0, 6) == 0);
      e = $urandom_range(0, d);
      ab = ($urandom_range(0, 9) == 0);
      a = $urandom_range(0, 6);
      dup = ($urandom_range(0, 2) == 0);
      hold = $urandom_range(0, 2);
      txn(4'($urandom), 2'($urandom), 1'($urandom), ha, d, he, e, ab, a, dup, hold, $urandom, n);
      repeat ($urandom_range(0, 2)) begin
        drv_slv(-1, 0, 0, 0);
        tick();
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
